// File: rtl/sample_packetiser_pkg.sv
// Shared types for the sample packetiser: stream structs, the stored sample word,
// packet FSM states and the byte-select helper used by the serialiser.
package sample_packetiser_pkg;

    typedef struct packed {
        logic signed [17:0] I;
        logic signed [17:0] Q;
        logic               Valid;
    } COMPLEX_STREAM;

    typedef struct packed {
        logic       SoP;
        logic       EoP;
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic [7:0] Data;
        logic       Valid;
    } UART_PACKET;

    localparam logic [7:0] SAMPLE_PACKETISER_DEST = 8'h03;

    typedef struct packed {
        logic [15:0] I;
        logic [15:0] Q;
    } SAMPLE_WORD;

    typedef enum logic {IDLE, SEND} PACKET_STATE;

    // Wire order of a sample: I high, I low, Q high, Q low.
    function automatic logic [7:0] sampleByte(input SAMPLE_WORD word, input logic [1:0] index);
        case (index)
            2'd0:    return word.I[15:8];
            2'd1:    return word.I[7:0];
            2'd2:    return word.Q[15:8];
            default: return word.Q[7:0];
        endcase
    endfunction

endpackage

// File: rtl/sample_packetiser_fifo.sv
// First-word-fall-through sample FIFO: the head word is always visible on
// opReadData while not empty; writes into a full FIFO are ignored.
module sample_fifo
    import sample_packetiser_pkg::*;
#(
    parameter int DEPTH = 64
)(
    input  logic                    ipClk,
    input  logic                    Reset,
    input  logic                    ipWrite,
    input  SAMPLE_WORD              ipWriteData,
    input  logic                    ipPop,
    output SAMPLE_WORD              opReadData,
    output logic                    opFull,
    output logic                    opEmpty,
    output logic [$clog2(DEPTH):0]  opLevel
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    SAMPLE_WORD        mem [DEPTH];
    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic              doWrite;
    logic              doPop;

    assign opFull  = (opLevel == FULL_LEVEL);
    assign opEmpty = (opLevel == '0);
    assign doWrite = ipWrite && !opFull;
    assign doPop   = ipPop && !opEmpty;

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            opLevel <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (doPop)   rdPtr <= rdPtr + 1'b1;
            case ({doWrite, doPop})
                2'b10:   opLevel <= opLevel + 1'b1;
                2'b01:   opLevel <= opLevel - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and level
    // define which entries are meaningful, and a resettable RAM cannot map to block memory.
    always_ff @(posedge ipClk) begin
        if (doWrite) mem[wrPtr] <= ipWriteData;
    end

    assign opReadData = mem[rdPtr];

endmodule

// File: rtl/sample_packetiser.sv
// Decimates the filtered I/Q stream, buffers kept samples and frames them into
// fixed-length UART packets, one byte per accepted handshake.
module sample_packetiser
    import sample_packetiser_pkg::*;
#(
    parameter int         SAMPLES_PER_PACKET = 16,
    parameter int         FIFO_DEPTH         = 64,
    parameter logic [7:0] SOURCE             = 8'h00,
    parameter logic [7:0] DESTINATION        = SAMPLE_PACKETISER_DEST
)(
    input  logic                         ipClk,
    input  logic                         Reset,
    input  logic                         ipEnable,
    input  logic [15:0]                  ipDecimation,
    input  COMPLEX_STREAM                ipInput,
    output UART_PACKET                   opTxStream,
    input  logic                         ipTxReady,
    output logic [15:0]                  opDropped,
    output logic [$clog2(FIFO_DEPTH):0]  opFIFO_Level
);

    localparam int               LEVEL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [7:0]       PACKET_BYTES = 8'(4 * SAMPLES_PER_PACKET);
    localparam logic [7:0]       LAST_BYTE    = PACKET_BYTES - 8'd1;
    localparam logic [LEVEL_W-1:0] PACKET_WORDS = LEVEL_W'(SAMPLES_PER_PACKET);

    logic [15:0] decCount;
    SAMPLE_WORD  keptWord;
    logic        keptValid;
    SAMPLE_WORD  headWord;
    logic        fifoFull;
    logic        fifoEmpty;
    logic        fifoPop;
    PACKET_STATE state;
    PACKET_STATE nextState;
    logic [7:0]  byteIndex;
    logic [7:0]  nextByteIndex;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            decCount  <= '0;
            keptValid <= 1'b0;
            keptWord  <= '0;
        end else begin
            keptValid <= 1'b0;
            if (!ipEnable) begin
                decCount <= '0;
            end else if (ipInput.Valid) begin
                if (decCount >= ipDecimation) begin
                    decCount  <= '0;
                    keptValid <= 1'b1;
                    keptWord  <= '{I: ipInput.I[17:2], Q: ipInput.Q[17:2]};
                end else begin
                    decCount <= decCount + 1'b1;
                end
            end
        end
    end

    // Fullness is the registered level, so a pop in the same cycle cannot make room.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            opDropped <= '0;
        end else if (keptValid && fifoFull && opDropped != 16'hFFFF) begin
            opDropped <= opDropped + 1'b1;
        end
    end

    sample_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .ipClk       (ipClk),
        .Reset       (Reset),
        .ipWrite     (keptValid),
        .ipWriteData (keptWord),
        .ipPop       (fifoPop),
        .opReadData  (headWord),
        .opFull      (fifoFull),
        .opEmpty     (fifoEmpty),
        .opLevel     (opFIFO_Level)
    );

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            state     <= IDLE;
            byteIndex <= '0;
        end else begin
            state     <= nextState;
            byteIndex <= nextByteIndex;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        nextState     = state;
        nextByteIndex = byteIndex;
        fifoPop       = 1'b0;
        case (state)
            IDLE: begin
                nextByteIndex = '0;
                if (opFIFO_Level >= PACKET_WORDS) nextState = SEND;
            end
            SEND: begin
                if (ipTxReady) begin
                    fifoPop = (byteIndex[1:0] == 2'd3);
                    if (byteIndex == LAST_BYTE) begin
                        nextState     = IDLE;
                        nextByteIndex = '0;
                    end else begin
                        nextByteIndex = byteIndex + 8'd1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs depend only on registers and the FIFO head, which only moves on an
    // accepted 4th byte, so fields stay stable while a byte waits for ipTxReady.
    always_comb begin
        opTxStream = '0;
        if (state == SEND) begin
            opTxStream.Valid       = 1'b1;
            opTxStream.SoP         = (byteIndex == 8'd0);
            opTxStream.EoP         = (byteIndex == LAST_BYTE);
            opTxStream.Source      = SOURCE;
            opTxStream.Destination = DESTINATION;
            opTxStream.Length      = PACKET_BYTES;
            opTxStream.Data        = sampleByte(headWord, byteIndex[1:0]);
        end
    end

endmodule

// File: tb/tb_sample_packetiser.sv
// Directed bench for sample_packetiser: decimation, byte order, backpressure,
// overflow and saturation, mid-packet reset and enable gating.
module tb_sample_packetiser;
    import sample_packetiser_pkg::*;

    logic          ipClk = 1'b0;
    logic          Reset;
    logic          ipEnable;
    logic [15:0]   ipDecimation;
    COMPLEX_STREAM ipInput;
    UART_PACKET    opTxStream;
    logic          ipTxReady;
    logic [15:0]   opDropped;
    logic [6:0]    opFIFO_Level;

    int         vectors     = 0;
    int         miscompares = 0;
    int         holdErrors  = 0;
    bit         randReady   = 1'b0;
    bit         holdPending = 1'b0;
    UART_PACKET heldByte;
    UART_PACKET rxQ[$];
    logic [7:0] expBytes[64];

    always #5 ipClk = ~ipClk;

    sample_packetiser dut (
        .ipClk        (ipClk),
        .Reset        (Reset),
        .ipEnable     (ipEnable),
        .ipDecimation (ipDecimation),
        .ipInput      (ipInput),
        .opTxStream   (opTxStream),
        .ipTxReady    (ipTxReady),
        .opDropped    (opDropped),
        .opFIFO_Level (opFIFO_Level)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Records accepted bytes and flags any held byte that changes before acceptance.
    always @(negedge ipClk) begin
        if (Reset) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending && opTxStream !== heldByte) holdErrors++;
            if (opTxStream.Valid && ipTxReady) rxQ.push_back(opTxStream);
            holdPending = opTxStream.Valid && !ipTxReady;
            heldByte    = opTxStream;
        end
    end

    task automatic step();
        @(posedge ipClk);
        #1;
        if (randReady) ipTxReady = 1'($urandom_range(0, 1));
    endtask

    task automatic sendSample(input logic [17:0] i, input logic [17:0] q);
        ipInput.I     = i;
        ipInput.Q     = q;
        ipInput.Valid = 1'b1;
        step();
    endtask

    task automatic idle(input int cycles);
        ipInput.Valid = 1'b0;
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic waitPacket(input int budget);
        ipInput.Valid = 1'b0;
        for (int c = 0; c < budget && rxQ.size() < 64; c++) step();
        step();
        step();
    endtask

    task automatic checkPacket(input string tag);
        UART_PACKET p;
        check({tag, " byte count"}, 64'(rxQ.size()), 64'd64);
        for (int b = 0; b < 64 && b < rxQ.size(); b++) begin
            p = rxQ[b];
            check({tag, " data"}, p.Data, expBytes[b]);
            check({tag, " sop/eop"}, {p.SoP, p.EoP}, {b == 0, b == 63});
            check({tag, " header"}, {p.Source, p.Destination, p.Length}, 24'h00_03_40);
        end
    endtask

    // Sixteen samples whose bytes read 0,1,2,...,63 on the wire.
    task automatic sendCountingPacket();
        for (int i = 0; i < 16; i++)
            sendSample({8'(4*i), 8'(4*i+1), 2'b00}, {8'(4*i+2), 8'(4*i+3), 2'b10});
        for (int b = 0; b < 64; b++) expBytes[b] = 8'(b);
    endtask

    initial begin
        Reset        = 1'b1;
        ipEnable     = 1'b0;
        ipDecimation = 16'd0;
        ipInput      = '0;
        ipTxReady    = 1'b0;
        idle(3);

        check("reset txStream", opTxStream, '0);
        check("reset dropped", opDropped, 16'd0);
        check("reset level", opFIFO_Level, 7'd0);
        Reset = 1'b0;
        step();

        // Decimation by 4: kept n = 4k+3, word I = k, Q = 0xFFFF - k.
        ipEnable     = 1'b1;
        ipDecimation = 16'd3;
        ipTxReady    = 1'b1;
        rxQ.delete();
        for (int n = 0; n < 64; n++) sendSample(18'(n), 18'(-n));
        for (int k = 0; k < 16; k++) begin
            expBytes[4*k]   = 8'h00;
            expBytes[4*k+1] = 8'(k);
            expBytes[4*k+2] = 8'hFF;
            expBytes[4*k+3] = 8'(255 - k);
        end
        waitPacket(400);
        checkPacket("decimate");
        check("decimate level after", opFIFO_Level, 7'd0);

        // Byte order of a single sample pattern.
        ipDecimation = 16'd0;
        rxQ.delete();
        for (int i = 0; i < 16; i++) sendSample(18'h1FFFC, 18'h20004);
        for (int b = 0; b < 64; b += 4) begin
            expBytes[b]   = 8'h7F;
            expBytes[b+1] = 8'hFF;
            expBytes[b+2] = 8'h80;
            expBytes[b+3] = 8'h01;
        end
        waitPacket(400);
        checkPacket("byte order");

        // Random backpressure.
        randReady = 1'b1;
        rxQ.delete();
        sendCountingPacket();
        waitPacket(2000);
        randReady = 1'b0;
        ipTxReady = 1'b1;
        checkPacket("backpressure");
        check("backpressure hold", 64'(holdErrors), 64'd0);
        idle(4);

        // Enable gating: a partly advanced counter must be cleared while disabled.
        ipDecimation = 16'd3;
        sendSample(18'h0, 18'h0);
        sendSample(18'h0, 18'h0);
        ipEnable = 1'b0;
        for (int i = 0; i < 5; i++) sendSample(18'h3FFFF, 18'h3FFFF);
        idle(3);
        check("disabled level", opFIFO_Level, 7'd0);
        ipEnable     = 1'b1;
        ipDecimation = 16'd1;
        rxQ.delete();
        for (int n = 0; n < 32; n++) begin
            sendSample({16'(n), 2'b01}, {16'h8000 | 16'(n), 2'b11});
            if (n == 1) check("kept level at t+1", opFIFO_Level, 7'd0);
            if (n == 2) check("kept level at t+2", opFIFO_Level, 7'd1);
        end
        for (int k = 0; k < 16; k++) begin
            expBytes[4*k]   = 8'h00;
            expBytes[4*k+1] = 8'(2*k + 1);
            expBytes[4*k+2] = 8'h80;
            expBytes[4*k+3] = 8'(2*k + 1);
        end
        waitPacket(400);
        checkPacket("re-enable");

        // Overflow with the sink stalled, then saturation of the drop counter.
        ipTxReady    = 1'b0;
        ipDecimation = 16'd0;
        for (int i = 0; i < 70; i++) sendSample(18'(i), 18'(i));
        idle(3);
        check("overflow level", opFIFO_Level, 7'd64);
        check("overflow dropped", opDropped, 16'd6);
        for (int i = 0; i < 65529; i++) sendSample(18'h0, 18'h0);
        idle(3);
        check("dropped at limit", opDropped, 16'hFFFF);
        for (int i = 0; i < 5; i++) sendSample(18'h0, 18'h0);
        idle(3);
        check("dropped saturated", opDropped, 16'hFFFF);

        // Reset while byte 20 of a packet is on the bus.
        rxQ.delete();
        ipTxReady = 1'b1;
        for (int c = 0; c < 200 && rxQ.size() < 20; c++) step();
        check("reached byte 20", 64'(rxQ.size()), 64'd20);
        check("byte 20 pending", opTxStream.Valid, 1'b1);
        Reset = 1'b1;
        step();
        check("mid reset valid", opTxStream.Valid, 1'b0);
        check("mid reset level", opFIFO_Level, 7'd0);
        check("mid reset dropped", opDropped, 16'd0);
        Reset = 1'b0;
        idle(2);

        rxQ.delete();
        sendCountingPacket();
        waitPacket(400);
        checkPacket("after reset");
        check("final hold", 64'(holdErrors), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
